// File: rtl/deser16_1.sv
// deser16_1: serial-to-parallel collector.
// Accepts one bit per cycle LSB first, assembles 16-bit words, and presents
// each completed word in a registered output stage with its own handshake.
module deser16_1 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic [3:0]  idx,
    output logic [15:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [15:0] asm_q, asm_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;

    logic accept;
    logic drain;
    logic complete;

    // Input handshake: stall only on the last bit while the held word is undrained.
    always_comb begin
        in_ready = !clear && !((idx_q == 4'd15) && out_valid_q && !out_ready);
        accept   = in_valid && in_ready;
        drain    = out_valid_q && out_ready;
        complete = accept && (idx_q == 4'd15);
    end

    // Next-state logic for the assembly register, position counter and output stage.
    always_comb begin
        // NOTE: every _d gets its current value first, so no path leaves it unassigned and no latch is inferred.
        asm_d       = asm_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            idx_d = 4'd0;
        end else if (accept) begin
            asm_d[idx_q] = in;
            idx_d        = idx_q + 4'd1;
        end

        // A completion wins over a drain in the same cycle, keeping out_valid high.
        if (complete) begin
            out_d       = {in, asm_q[14:0]};
            out_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards both the partial and the pending word.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            asm_q       <= 16'h0000;
            idx_q       <= 4'd0;
            out_q       <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign idx       = idx_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_deser16_1.sv
// Self-checking bench for deser16_1: directed scenarios followed by random
// traffic, compared against a word-level reference model.
module tb_deser16_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [3:0]  idx;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;

    int vectors = 0;
    int errors  = 0;

    // Reference model: number of bits collected, word built so far, held word.
    int          m_cnt;
    logic [15:0] m_word;
    logic [15:0] m_out;
    logic        m_valid;

    always #5 clk = ~clk;

    deser16_1 dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .idx       (idx),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_word  = 16'h0000;
        m_out   = 16'h0000;
        m_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".idx"},       {12'h0, idx},      16'(m_cnt));
        chk({tag, ".out"},       out,               m_out);
        chk({tag, ".out_valid"}, {15'h0, out_valid}, {15'h0, m_valid});
    endtask

    // One clock cycle: drive at negedge, check in_ready, clock, check state.
    task automatic step(input logic b, input logic v, input logic cl, input logic ordy);
        logic exp_ready;
        logic acc;
        logic done;
        @(negedge clk);
        din       = b;
        in_valid  = v;
        clear     = cl;
        out_ready = ordy;
        #1;
        exp_ready = !cl && !(m_cnt == 15 && m_valid && !ordy);
        chk("in_ready", {15'h0, in_ready}, {15'h0, exp_ready});
        acc  = v && exp_ready;
        done = 1'b0;
        if (cl) begin
            m_cnt  = 0;
            m_word = 16'h0000;
        end else if (acc) begin
            m_word = m_word | (16'(b) << m_cnt);
            if (m_cnt == 15) begin
                m_out   = m_word;
                m_valid = 1'b1;
                done    = 1'b1;
                m_cnt   = 0;
                m_word  = 16'h0000;
            end else begin
                m_cnt++;
            end
        end
        if (!done && ordy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_state("step");
    endtask

    task automatic send_word(input logic [15:0] w, input logic ordy);
        for (int i = 0; i < 16; i++) step(w[i], 1'b1, 1'b0, ordy);
    endtask

    initial begin
        logic [15:0] w;
        model_reset();
        reset = 1'b1; din = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset.in_ready", {15'h0, in_ready}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;

        // Single word, no drain.
        send_word(16'h39CA, 1'b0);
        chk("single.out", out, 16'h39CA);
        chk("single.valid", {15'h0, out_valid}, 16'h0001);
        chk("single.idx", {12'h0, idx}, 16'h0000);

        // Back-to-back with drain: zero bubble across the boundary.
        send_word(16'h39CA, 1'b1);
        send_word(16'hA5F0, 1'b1);
        chk("b2b.out", out, 16'hA5F0);
        chk("b2b.valid", {15'h0, out_valid}, 16'h0001);

        // Backpressure on the 16th bit.
        w = 16'h0F0F;
        for (int i = 0; i < 15; i++) step(w[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(w[15], 1'b1, 1'b0, 1'b0);
            chk("bp.idx_held", {12'h0, idx}, 16'h000F);
            chk("bp.out_held", out, 16'hA5F0);
        end
        step(w[15], 1'b1, 1'b0, 1'b1);
        chk("bp.out", out, 16'h0F0F);
        chk("bp.valid", {15'h0, out_valid}, 16'h0001);

        // Clear mid-word at idx 9, then a fresh word.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr.idx9", {12'h0, idx}, 16'h0009);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr.idx0", {12'h0, idx}, 16'h0000);
        send_word(16'h1234, 1'b0);
        chk("clr.out", out, 16'h1234);

        // Gapped input: in_valid every other cycle.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("gap.out", out, 16'hFFFF);
        chk("gap.valid", {15'h0, out_valid}, 16'h0001);

        // Asynchronous reset mid-word with a pending word.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst.idx7", {12'h0, idx}, 16'h0007);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state("rst_async");
        chk("rst.in_ready", {15'h0, in_ready}, 16'h0001);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(40) == 0),
                 ($urandom_range(2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
